// File: rtl/dac_cfg_serializer.sv
// Bit-banged GPIO configuration transmitter for dac_driver: shifts a word out on sdata
// with one strobe per register. Optional done counter: define DAC_CFG_DONE_CNT_EN.
module dac_cfg_serializer #(
    parameter int GPIO_WIDTH               = 16,
    parameter int WORD_BITS                = 256,
    parameter int PHASE_CYCLES             = 2,
    parameter int MUX_PULSES               = 8,
    parameter int SDATA_BIT                = 0,
    parameter int CYCLE_COUNT_CLK_BIT      = 1,
    parameter int MASK_CLK_BIT             = 2,
    parameter int DELAY_CYCLE_CLK_BIT      = 3,
    parameter int LOCKING_WAVEFORM_CLK_BIT = 4,
    parameter int MUX_SET_CLK_BIT          = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WORD_BITS-1:0]  cfg_data,
    input  logic [2:0]            cfg_target,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    output logic [GPIO_WIDTH-1:0] gpio_ctrl,
    output logic                  select_out,
`ifdef DAC_CFG_DONE_CNT_EN
    output logic [15:0]           done_count,
`endif
    output logic                  cfg_err
);

    localparam int MAX_BITS = (WORD_BITS > MUX_PULSES) ? WORD_BITS : MUX_PULSES;
    localparam int CNT_W    = $clog2(MAX_BITS) + 1;
    localparam int PH_W     = (PHASE_CYCLES > 1) ? $clog2(PHASE_CYCLES) : 1;

    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(WORD_BITS - 1);
    localparam logic [CNT_W-1:0] LAST_MUX  = CNT_W'(MUX_PULSES - 1);
    localparam logic [PH_W-1:0]  LAST_PH   = PH_W'(PHASE_CYCLES - 1);

    localparam logic [2:0] T_CYCLE_COUNT = 3'd0;
    localparam logic [2:0] T_MASK        = 3'd1;
    localparam logic [2:0] T_DELAY_CYCLE = 3'd2;
    localparam logic [2:0] T_LOCKING_WF  = 3'd3;
    localparam logic [2:0] T_MUX_SET     = 3'd4;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        HIGH,
        LOW,
        FINISH
    } state_t;

    state_t                  state_q, state_n;
    logic [WORD_BITS-1:0]    shift_q, shift_n;
    logic [2:0]              tgt_q, tgt_n;
    logic [CNT_W-1:0]        bit_q, bit_n;
    logic [PH_W-1:0]         ph_q, ph_n;
    logic                    inv_q, inv_n;
    logic [GPIO_WIDTH-1:0]   gpio_q, gpio_n;
    logic                    sel_q, sel_n;
    logic                    err_q, err_n;
    logic                    ph_done;
    logic                    last_bit;

    assign cfg_ready  = (state_q == IDLE);
    assign gpio_ctrl  = gpio_q;
    assign select_out = sel_q;
    assign cfg_err    = err_q;

    assign ph_done  = (ph_q == LAST_PH);
    assign last_bit = (tgt_q == T_MUX_SET) ? (bit_q == LAST_MUX) : (bit_q == LAST_WORD);

    always_comb begin
        state_n = state_q;
        shift_n = shift_q;
        tgt_n   = tgt_q;
        bit_n   = bit_q;
        ph_n    = ph_q;
        inv_n   = inv_q;

        unique case (state_q)
            IDLE: begin
                if (cfg_valid) begin
                    shift_n = cfg_data;
                    tgt_n   = cfg_target;
                    bit_n   = '0;
                    ph_n    = '0;
                    // invalid targets skip the bus entirely and only report cfg_err
                    if (cfg_target <= T_MUX_SET) begin
                        inv_n   = 1'b0;
                        state_n = SETUP;
                    end else begin
                        inv_n   = 1'b1;
                        state_n = FINISH;
                    end
                end
            end
            SETUP: begin
                if (ph_done) begin
                    ph_n    = '0;
                    state_n = HIGH;
                end else begin
                    ph_n = ph_q + PH_W'(1);
                end
            end
            HIGH: begin
                if (ph_done) begin
                    ph_n    = '0;
                    state_n = LOW;
                end else begin
                    ph_n = ph_q + PH_W'(1);
                end
            end
            LOW: begin
                if (ph_done) begin
                    ph_n = '0;
                    if (last_bit) begin
                        state_n = FINISH;
                    end else begin
                        bit_n   = bit_q + CNT_W'(1);
                        // mux select repeats bit 0 for every pulse
                        if (tgt_q != T_MUX_SET)
                            shift_n = shift_q >> 1;
                        state_n = SETUP;
                    end
                end else begin
                    ph_n = ph_q + PH_W'(1);
                end
            end
            FINISH: begin
                inv_n   = 1'b0;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Outputs are decoded from the next state and registered so the bus is glitch-free.
    always_comb begin
        sel_n  = (state_n == SETUP) || (state_n == HIGH) || (state_n == LOW);
        gpio_n = '0;
        gpio_n[SDATA_BIT] = sel_n & shift_n[0];
        if (state_n == HIGH) begin
            unique case (tgt_n)
                T_CYCLE_COUNT: gpio_n[CYCLE_COUNT_CLK_BIT]      = 1'b1;
                T_MASK:        gpio_n[MASK_CLK_BIT]             = 1'b1;
                T_DELAY_CYCLE: gpio_n[DELAY_CYCLE_CLK_BIT]      = 1'b1;
                T_LOCKING_WF:  gpio_n[LOCKING_WAVEFORM_CLK_BIT] = 1'b1;
                T_MUX_SET:     gpio_n[MUX_SET_CLK_BIT]          = 1'b1;
                default:       gpio_n = gpio_n;
            endcase
        end
        err_n = (state_n == FINISH) && inv_n;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            shift_q <= '0;
            tgt_q   <= '0;
            bit_q   <= '0;
            ph_q    <= '0;
            inv_q   <= 1'b0;
            gpio_q  <= '0;
            sel_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_n;
            shift_q <= shift_n;
            tgt_q   <= tgt_n;
            bit_q   <= bit_n;
            ph_q    <= ph_n;
            inv_q   <= inv_n;
            gpio_q  <= gpio_n;
            sel_q   <= sel_n;
            err_q   <= err_n;
        end
    end

`ifdef DAC_CFG_DONE_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            done_count <= '0;
        else if (state_q == FINISH && !inv_q)
            done_count <= done_count + 16'd1;
    end
`endif

endmodule
